cmd_serializer: RTL and testbench

- Packs one structured master-controller command (opcode, id, payload) into the 32-bit word stream that feeds the command FIFO.
- Output stream: header word first, then payload words 1..N, low word first.
- Used by the host-side sequencer and the bench to generate F0–F5 command streams, so the encoding and the decoder share a single source of truth.

---
 rtl/cmd_serializer_pkg.sv | 65 ++++++
 rtl/cmd_serializer.sv | 186 ++++++++++++++++++
 tb/tb_cmd_serializer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cmd_serializer_pkg.sv
// Purpose: shared command encoding for cmd_serializer and its consumers.
//   Holds the opcode enum, header/payload layouts, stream widths and the
//   opcode -> payload-word-count lookup used by both encoder and decoder.
// Contents:
//   WORD_W / PAY_W            output word width / packed payload width
//   cmd_pay_max_words_gp      largest payload, in words
//   cmd_op_s                  opcode enum (F0..F5)
//   cmd_header_s              header word {rsvd, len_bytes, id, op}
//   cmd_tile_s                tile payload layout (largest payload)
//   cmd_pay_words()           payload words for an opcode, 0 = illegal
package cmd_serializer_pkg;

  localparam int unsigned WORD_W               = 32;
  localparam int unsigned PAY_W                = 96;
  localparam int unsigned cmd_pay_max_words_gp = 3;
  localparam int unsigned CMD_IDX_W            = $clog2(cmd_pay_max_words_gp + 1);
  localparam int unsigned CMD_CNT_W            = 16;
  localparam int unsigned CMD_ID_W             = 8;
  localparam int unsigned CMD_OP_W             = 8;

  typedef enum logic [CMD_OP_W-1:0] {
    CMD_FETCH     = 8'hF0,
    CMD_DISP      = 8'hF1,
    CMD_TILE      = 8'hF2,
    CMD_WAIT_DISP = 8'hF3,
    CMD_WAIT_TILE = 8'hF4,
    CMD_READOUT   = 8'hF5
  } cmd_op_s;

  // Header word as it appears on word_o, op in the low byte.
  typedef struct packed {
    logic [7:0]          rsvd;
    logic [7:0]          len;
    logic [CMD_ID_W-1:0] id;
    logic [CMD_OP_W-1:0] op;
  } cmd_header_s;

  // Tile payload: word1 = addresses, word2 = vector length, word3 = column enables.
  typedef struct packed {
    logic [31:0] col_en;
    logic [15:0] rsvd;
    logic [15:0] vec_len;
    logic [15:0] left_addr;
    logic [15:0] right_addr;
  } cmd_tile_s;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } ser_state_e;

  // Payload word count per opcode; zero marks an illegal opcode.
  function automatic logic [CMD_IDX_W-1:0] cmd_pay_words(input cmd_op_s op);
    logic [CMD_IDX_W-1:0] n;
    case (op)
      CMD_FETCH, CMD_DISP, CMD_TILE: n = CMD_IDX_W'(3);
      CMD_WAIT_DISP, CMD_WAIT_TILE:  n = CMD_IDX_W'(1);
      CMD_READOUT:                   n = CMD_IDX_W'(2);
      default:                       n = CMD_IDX_W'(0);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cmd_serializer.sv
// Purpose: serialize one command (opcode, id, payload) into a 32-bit word
//   stream: a header word followed by 1..3 payload words, low word first.
//   Illegal opcodes are accepted and dropped with a one-cycle err_o pulse.
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   cmd_v_i/cmd_ready_o    command handshake (ready only while idle)
//   cmd_op_i, cmd_id_i     opcode and id for the header
//   cmd_payload_i          LSB-aligned packed payload
//   word_v_o/word_ready_i  output stream handshake, word_o data
//   busy_o                 command in flight
//   err_o                  pulse after an illegal opcode is accepted
//   cmd_cnt_o              commands fully emitted (wraps)
//   last_id_o              only with CMD_SER_AUTO_ID_EN: last issued id
// Build option CMD_SER_AUTO_ID_EN: header ids come from an internal counter
//   (1..255, skipping 0) instead of cmd_id_i.
module cmd_serializer
  import cmd_serializer_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cmd_v_i,
  output logic                 cmd_ready_o,
  input  logic [CMD_OP_W-1:0]  cmd_op_i,
  input  logic [CMD_ID_W-1:0]  cmd_id_i,
  input  logic [PAY_W-1:0]     cmd_payload_i,
  output logic                 word_v_o,
  output logic [WORD_W-1:0]    word_o,
  input  logic                 word_ready_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [CMD_CNT_W-1:0] cmd_cnt_o
`ifdef CMD_SER_AUTO_ID_EN
  ,
  output logic [CMD_ID_W-1:0]  last_id_o
`endif
);

  ser_state_e           state_q, state_d;
  logic                 word_v_q, word_v_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [PAY_W-1:0]     pay_q, pay_d;
  logic [CMD_IDX_W-1:0] count_q, count_d;
  logic [CMD_IDX_W-1:0] idx_q, idx_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [CMD_CNT_W-1:0] cnt_q, cnt_d;

  logic [CMD_IDX_W-1:0] words_c;
  logic [CMD_ID_W-1:0]  hdr_id_c;
  cmd_header_s          hdr_c;

  assign words_c = cmd_pay_words(cmd_op_s'(cmd_op_i));

`ifdef CMD_SER_AUTO_ID_EN
  logic [CMD_ID_W-1:0] id_q, id_d;
  logic [CMD_ID_W-1:0] last_id_q, last_id_d;
  logic                unused_id_c;

  assign unused_id_c = ^cmd_id_i;
  assign hdr_id_c    = id_q;
  assign last_id_o   = last_id_q;

  // Id counter: advances on each accepted legal command, 255 wraps to 1.
  always_comb begin
    id_d      = id_q;
    last_id_d = last_id_q;
    if ((state_q == ST_IDLE) && cmd_v_i && (words_c != '0)) begin
      last_id_d = id_q;
      id_d      = (id_q == CMD_ID_W'(255)) ? CMD_ID_W'(1) : id_q + CMD_ID_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      id_q      <= CMD_ID_W'(1);
      last_id_q <= '0;
    end else begin
      id_q      <= id_d;
      last_id_q <= last_id_d;
    end
  end
`else
  assign hdr_id_c = cmd_id_i;
`endif

  // Header word for the command currently on the input.
  always_comb begin
    hdr_c      = '0;
    hdr_c.len  = 8'({words_c, 2'b00});
    hdr_c.id   = hdr_id_c;
    hdr_c.op   = cmd_op_i;
  end

  // Next-state and datapath. pay_q[WORD_W-1:0] always mirrors the payload
  // word on word_o during PAY, so the next word is simply the one above it.
  always_comb begin
    state_d = state_q;
    word_v_d = word_v_q;
    word_d   = word_q;
    pay_d    = pay_q;
    count_d  = count_q;
    idx_d    = idx_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_v_i) begin
          if (words_c != '0) begin
            pay_d    = cmd_payload_i;
            count_d  = words_c;
            word_d   = WORD_W'(hdr_c);
            word_v_d = 1'b1;
            state_d  = ST_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (word_ready_i) begin
          word_d  = pay_q[WORD_W-1:0];
          idx_d   = CMD_IDX_W'(1);
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (word_ready_i) begin
          if (idx_q == count_q) begin
            word_v_d = 1'b0;
            word_d   = '0;
            cnt_d    = cnt_q + CMD_CNT_W'(1);
            state_d  = ST_IDLE;
          end else begin
            idx_d  = idx_q + CMD_IDX_W'(1);
            word_d = pay_q[2*WORD_W-1:WORD_W];
            pay_d  = pay_q >> WORD_W;
          end
        end
      end
      default: begin
        word_v_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any command in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      word_v_q <= 1'b0;
      word_q   <= '0;
      pay_q    <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      word_v_q <= word_v_d;
      word_q   <= word_d;
      pay_q    <= pay_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign word_v_o    = word_v_q;
  assign word_o      = word_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign cmd_cnt_o   = cnt_q;

endmodule

// File: tb/tb_cmd_serializer.sv
// Purpose: directed self-checking bench for cmd_serializer. Expected words
//   are hand-computed constants; header ids follow a small id model when
//   CMD_SER_AUTO_ID_EN is defined.
module tb_cmd_serializer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cmd_v_i;
  logic        cmd_ready_o;
  logic [7:0]  cmd_op_i;
  logic [7:0]  cmd_id_i;
  logic [95:0] cmd_payload_i;
  logic        word_v_o;
  logic [31:0] word_o;
  logic        word_ready_i;
  logic        busy_o;
  logic        err_o;
  logic [15:0] cmd_cnt_o;
`ifdef CMD_SER_AUTO_ID_EN
  logic [7:0]  last_id_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] model_id = 8'd1;

  always #5 clk_i = ~clk_i;

  cmd_serializer dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .cmd_v_i       (cmd_v_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_op_i      (cmd_op_i),
    .cmd_id_i      (cmd_id_i),
    .cmd_payload_i (cmd_payload_i),
    .word_v_o      (word_v_o),
    .word_o        (word_o),
    .word_ready_i  (word_ready_i),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .cmd_cnt_o     (cmd_cnt_o)
`ifdef CMD_SER_AUTO_ID_EN
    ,
    .last_id_o     (last_id_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Header word expected for a legal command; id replaced by the model in auto-id builds.
  task automatic issue(input logic [7:0] op, input logic [7:0] id, input logic [95:0] pay,
                       input logic [7:0] len, output logic [31:0] hdr);
    logic [7:0] hid;
    int wait_cyc;
    hid = id;
`ifdef CMD_SER_AUTO_ID_EN
    if (len != 8'd0) begin
      hid = model_id;
      model_id = (model_id == 8'd255) ? 8'd1 : model_id + 8'd1;
    end
`endif
    hdr = {8'h00, len, hid, op};
    wait_cyc = 0;
    while (!cmd_ready_o && wait_cyc < 20) begin
      @(negedge clk_i);
      wait_cyc++;
    end
    if (!cmd_ready_o) chk("ready_timeout", 32'(cmd_ready_o), 32'd1);
    cmd_v_i = 1'b1;
    cmd_op_i = op;
    cmd_id_i = id;
    cmd_payload_i = pay;
    @(negedge clk_i);
    cmd_v_i = 1'b0;
    cmd_payload_i = '0;
  endtask

  // Check one word, holding it stalled for 'stalls' cycles first, then transfer it.
  task automatic take_word(input string tag, input logic [31:0] exp, input int stalls);
    for (int s = 0; s < stalls; s++) begin
      word_ready_i = 1'b0;
      chk({tag, "_stall_v"}, 32'(word_v_o), 32'd1);
      chk({tag, "_stall_d"}, word_o, exp);
      @(negedge clk_i);
    end
    word_ready_i = 1'b1;
    chk({tag, "_v"}, 32'(word_v_o), 32'd1);
    chk({tag, "_d"}, word_o, exp);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    word_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    model_id = 8'd1;
  endtask

  initial begin
    logic [31:0] h;
    reset_i = 1'b1;
    cmd_v_i = 1'b0;
    cmd_op_i = '0;
    cmd_id_i = '0;
    cmd_payload_i = '0;
    word_ready_i = 1'b0;
    do_reset();

    chk("rst_word_v", 32'(word_v_o), 32'd0);
    chk("rst_word", word_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cnt", 32'(cmd_cnt_o), 32'd0);
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);

    // Tile: word1 = {left,right}, word2 = vec_len, word3 = col_en.
    word_ready_i = 1'b1;
    issue(8'hF2, 8'h07, {32'h0000_0001, 32'h0000_0004, 32'h0100_0200}, 8'd12, h);
    chk("tile_busy", 32'(busy_o), 32'd1);
    chk("tile_ready", 32'(cmd_ready_o), 32'd0);
`ifndef CMD_SER_AUTO_ID_EN
    chk("tile_hdr_const", word_o, 32'h000C07F2);
`endif
    take_word("tile_hdr", h, 0);
    take_word("tile_w1", 32'h0100_0200, 0);
    take_word("tile_w2", 32'h0000_0004, 0);
    take_word("tile_w3", 32'h0000_0001, 0);
    chk("tile_done_v", 32'(word_v_o), 32'd0);
    chk("tile_cnt", 32'(cmd_cnt_o), 32'd1);
    chk("tile_idle_ready", 32'(cmd_ready_o), 32'd1);

    // Wait_tile: exactly two words.
    issue(8'hF4, 8'h03, 96'h2, 8'd4, h);
    take_word("wt_hdr", h, 0);
    take_word("wt_w1", 32'h0000_0002, 0);
    chk("wt_done_v", 32'(word_v_o), 32'd0);
    chk("wt_cnt", 32'(cmd_cnt_o), 32'd2);

    // Readout with sink stalling every other cycle.
    issue(8'hF5, 8'h00, {32'h0, 32'h0000_0100, 32'h0000_0005}, 8'd8, h);
    take_word("ro_hdr", h, 1);
    take_word("ro_w1", 32'h0000_0005, 1);
    take_word("ro_w2", 32'h0000_0100, 1);
    chk("ro_done_v", 32'(word_v_o), 32'd0);
    chk("ro_cnt", 32'(cmd_cnt_o), 32'd3);

    // Illegal opcode: accepted, err pulse, nothing emitted.
    issue(8'h42, 8'h09, 96'hABC, 8'd0, h);
    chk("ill_err", 32'(err_o), 32'd1);
    chk("ill_v", 32'(word_v_o), 32'd0);
    chk("ill_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    chk("ill_err_clr", 32'(err_o), 32'd0);
    chk("ill_v2", 32'(word_v_o), 32'd0);
    chk("ill_cnt", 32'(cmd_cnt_o), 32'd3);

    // Fetch cut short by reset after the header transfer.
    issue(8'hF0, 8'h11, {32'h3, 32'h2, 32'h1}, 8'd12, h);
    take_word("f0_hdr", h, 0);
    chk("f0_w1_pending", word_o, 32'h0000_0001);
    do_reset();
    chk("f0_rst_v", 32'(word_v_o), 32'd0);
    chk("f0_rst_cnt", 32'(cmd_cnt_o), 32'd0);
    chk("f0_rst_busy", 32'(busy_o), 32'd0);
    chk("f0_rst_ready", 32'(cmd_ready_o), 32'd1);
    word_ready_i = 1'b1;
    issue(8'hF3, 8'h09, 96'h33, 8'd4, h);
    take_word("wd_hdr", h, 0);
    take_word("wd_w1", 32'h0000_0033, 0);
    chk("wd_done_v", 32'(word_v_o), 32'd0);
    chk("wd_cnt", 32'(cmd_cnt_o), 32'd1);

`ifdef CMD_SER_AUTO_ID_EN
    // 256 back-to-back waits: ids 1..255 then wrap to 1.
    do_reset();
    word_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      issue(8'hF4, 8'hAA, 96'(i), 8'd4, h);
      chk("auto_hdr_id", 32'(word_o[15:8]), 32'((i % 255) + 1));
      chk("auto_last_id", 32'(last_id_o), 32'((i % 255) + 1));
      take_word("auto_hdr", h, 0);
      take_word("auto_w1", 32'(i), 0);
    end
    chk("auto_cnt", 32'(cmd_cnt_o), 32'd256);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
